// File: rtl/sram_pkg.sv
// Shared defaults and state type for the SRAM request controller.
package sram_pkg;

  localparam int unsigned SRAM_WIDTH        = 512;
  localparam int unsigned SRAM_LOG_NUM_ROWS = 9;
  localparam int unsigned SRAM_WORD_SIZE    = 64;

  typedef enum logic [0:0] {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/sram_rsp_fifo.sv
// Two-entry response buffer holding SRAM read data the client has not yet taken.
module sram_rsp_fifo #(
  parameter int unsigned WIDTH = 512
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic [1:0]       o_count
);

  logic [WIDTH-1:0] r_mem [2];
  logic             r_wr_ptr;
  logic             r_rd_ptr;
  logic [1:0]       r_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (i_push) r_wr_ptr <= ~r_wr_ptr;
      if (i_pop)  r_rd_ptr <= ~r_rd_ptr;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset; occupancy is tracked by r_count alone.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/sram_req_ctrl.sv
// Single-port-style request front end for a 1R1W SRAM: zero-fill sweep after reset,
// masked writes, and in-order read responses with a 2-deep skid buffer for backpressure.
module sram_req_ctrl
  import sram_pkg::*;
#(
  parameter int unsigned WIDTH          = SRAM_WIDTH,
  parameter int unsigned LOG_NUM_ROWS   = SRAM_LOG_NUM_ROWS,
  parameter int unsigned WORD_SIZE      = SRAM_WORD_SIZE,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         reqValid,
  output logic                         reqReady,
  input  logic                         reqWrite,
  input  logic [LOG_NUM_ROWS-1:0]      reqAddr,
  input  logic [WIDTH-1:0]             reqData,
  input  logic [WIDTH/WORD_SIZE-1:0]   reqMask,
  output logic                         rspValid,
  input  logic                         rspReady,
  output logic [WIDTH-1:0]             rspData,
  output logic [LOG_NUM_ROWS-1:0]      sramReadAddr,
  input  logic [WIDTH-1:0]             sramReadData,
  output logic [LOG_NUM_ROWS-1:0]      sramWriteAddr,
  output logic [WIDTH-1:0]             sramWriteData,
  output logic [WIDTH/WORD_SIZE-1:0]   sramWriteEnable,
  output logic                         initDone
);

  localparam int unsigned NM       = WIDTH / WORD_SIZE;
  localparam int unsigned NUM_ROWS = 2 ** LOG_NUM_ROWS;

  state_e                  r_state;
  state_e                  w_state_nxt;
  logic [LOG_NUM_ROWS-1:0] r_row;
  logic [LOG_NUM_ROWS-1:0] w_row_nxt;
  logic [LOG_NUM_ROWS-1:0] r_read_addr;
  logic                    r_pending;

  logic                    w_run;
  logic                    w_accept;
  logic                    w_accept_rd;
  logic                    w_accept_wr;
  logic [2:0]              w_outstanding;
  logic                    w_fifo_empty;
  logic                    w_push;
  logic                    w_pop;
  logic [1:0]              w_fifo_count;
  logic [WIDTH-1:0]        w_fifo_head;

  // Outputs are gated by reset so the reset cycle itself is quiet.
  assign w_run         = (r_state == RUN) && !reset;
  assign w_outstanding = {1'b0, w_fifo_count} + {2'b00, r_pending};
  assign reqReady      = w_run && (w_outstanding < 3'd2);
  assign w_accept      = reqValid && reqReady;
  assign w_accept_rd   = w_accept && !reqWrite;
  assign w_accept_wr   = w_accept && reqWrite;
  assign initDone      = w_run;

  // Pending data bypasses the buffer only when nothing older is queued and the client takes it.
  assign w_fifo_empty  = (w_fifo_count == 2'd0);
  assign rspValid      = !reset && (r_pending || !w_fifo_empty);
  assign rspData       = w_fifo_empty ? sramReadData : w_fifo_head;
  assign w_pop         = rspValid && rspReady && !w_fifo_empty;
  assign w_push        = !reset && r_pending && !(w_fifo_empty && rspReady);

  sram_rsp_fifo #(
    .WIDTH (WIDTH)
  ) u_rsp_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_data  (sramReadData),
    .i_pop   (w_pop),
    .o_head  (w_fifo_head),
    .o_count (w_fifo_count)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_row_nxt   = r_row;
    if (r_state == INIT) begin
      w_row_nxt = r_row + LOG_NUM_ROWS'(1);
      if (r_row == LOG_NUM_ROWS'(NUM_ROWS - 1)) w_state_nxt = RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      if (CLEAR_ON_RESET) r_state <= INIT;
      else                r_state <= RUN;
      r_row       <= '0;
      r_pending   <= 1'b0;
      r_read_addr <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_row     <= w_row_nxt;
      r_pending <= w_accept_rd;
      if (w_accept_rd) r_read_addr <= reqAddr;
    end
  end

  // Write port: sweep row during INIT, client write on accept, idle otherwise.
  always_comb begin
    sramWriteAddr   = reqAddr;
    sramWriteData   = reqData;
    sramWriteEnable = '0;
    if (!reset && (r_state == INIT)) begin
      sramWriteAddr   = r_row;
      sramWriteData   = '0;
      sramWriteEnable = '1;
    end else if (w_accept_wr) begin
      sramWriteEnable = reqMask;
    end
  end

  assign sramReadAddr = w_accept_rd ? reqAddr : r_read_addr;

endmodule

// File: tb/tb_sram_req_ctrl.sv
// Directed plus randomized check of sram_req_ctrl against a row-array/queue reference.
module tb_sram_req_ctrl;
  import sram_pkg::*;

  localparam int unsigned W    = SRAM_WIDTH;
  localparam int unsigned AW   = SRAM_LOG_NUM_ROWS;
  localparam int unsigned WS   = SRAM_WORD_SIZE;
  localparam int unsigned NM   = W / WS;
  localparam int unsigned ROWS = 1 << AW;

  logic          clk = 1'b0;
  logic          reset;
  logic          reqValid;
  logic          reqReady;
  logic          reqWrite;
  logic [AW-1:0] reqAddr;
  logic [W-1:0]  reqData;
  logic [NM-1:0] reqMask;
  logic          rspValid;
  logic          rspReady;
  logic [W-1:0]  rspData;
  logic [AW-1:0] sramReadAddr;
  logic [W-1:0]  sramReadData;
  logic [AW-1:0] sramWriteAddr;
  logic [W-1:0]  sramWriteData;
  logic [NM-1:0] sramWriteEnable;
  logic          initDone;

  always #5 clk = ~clk;

  sram_req_ctrl dut (
    .clk             (clk),
    .reset           (reset),
    .reqValid        (reqValid),
    .reqReady        (reqReady),
    .reqWrite        (reqWrite),
    .reqAddr         (reqAddr),
    .reqData         (reqData),
    .reqMask         (reqMask),
    .rspValid        (rspValid),
    .rspReady        (rspReady),
    .rspData         (rspData),
    .sramReadAddr    (sramReadAddr),
    .sramReadData    (sramReadData),
    .sramWriteAddr   (sramWriteAddr),
    .sramWriteData   (sramWriteData),
    .sramWriteEnable (sramWriteEnable),
    .initDone        (initDone)
  );

  // Environment SRAM: masked write, registered read.
  logic [W-1:0] sram_mem [ROWS];
  always @(posedge clk) begin
    for (int w = 0; w < int'(NM); w++)
      if (sramWriteEnable[w]) sram_mem[sramWriteAddr][w*WS +: WS] <= sramWriteData[w*WS +: WS];
    sramReadData <= sram_mem[sramReadAddr];
  end

  logic [W-1:0] ref_mem [ROWS];
  logic [W-1:0] exp_q [$];
  bit           model_run;
  int           total;
  int           bad;
  int           n_rsp;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] apply_mask(input logic [W-1:0] old, input logic [W-1:0] d,
                                               input logic [NM-1:0] m);
    logic [W-1:0] r;
    r = old;
    for (int w = 0; w < int'(NM); w++)
      if (m[w]) r[w*WS +: WS] = d[w*WS +: WS];
    return r;
  endfunction

  function automatic logic [W-1:0] rand_row();
    logic [W-1:0] r;
    for (int i = 0; i < int'(W / 32); i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // One clock of stimulus; outstanding = accepted reads not yet taken by the client.
  task automatic step(input logic v, input logic wr, input logic [AW-1:0] a, input logic [W-1:0] d,
                      input logic [NM-1:0] m, input logic rr, output logic acc);
    logic er;
    logic ev;
    logic [NM-1:0] ewe;
    @(negedge clk);
    reqValid = v; reqWrite = wr; reqAddr = a; reqData = d; reqMask = m; rspReady = rr;
    #1;
    er = model_run && (exp_q.size() < 2);
    ev = exp_q.size() > 0;
    chk("reqReady", W'(reqReady), W'(er));
    chk("rspValid", W'(rspValid), W'(ev));
    if (ev) chk("rspData", rspData, exp_q[0]);
    acc = v && er;
    ewe = (acc && wr) ? m : '0;
    chk("sramWriteEnable", W'(sramWriteEnable), W'(ewe));
    if (acc && wr) begin
      chk("sramWriteAddr", W'(sramWriteAddr), W'(a));
      chk("sramWriteData", sramWriteData, d);
    end
    if (acc && !wr) chk("sramReadAddr", W'(sramReadAddr), W'(a));
    if (ev && rr) begin
      void'(exp_q.pop_front());
      n_rsp++;
    end
    if (acc) begin
      if (wr) ref_mem[a] = apply_mask(ref_mem[a], d, m);
      else    exp_q.push_back(ref_mem[a]);
    end
  endtask

  task automatic rd(input logic [AW-1:0] a, input logic rr, output logic acc);
    step(1'b1, 1'b0, a, '0, '0, rr, acc);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [W-1:0] d, input logic [NM-1:0] m);
    logic acc;
    step(1'b1, 1'b1, a, d, m, 1'b1, acc);
    chk("write_accepted", W'(acc), W'(1'b1));
  endtask

  task automatic idle(input logic rr);
    logic acc;
    step(1'b0, 1'b0, '0, '0, '0, rr, acc);
  endtask

  // Reset cycle, then the zero-fill sweep must take exactly ROWS cycles.
  task automatic do_reset();
    int n;
    @(negedge clk);
    reqValid = 1'b0; rspReady = 1'b1; reset = 1'b1;
    #1;
    chk("rst_reqReady", W'(reqReady), W'(1'b0));
    chk("rst_rspValid", W'(rspValid), W'(1'b0));
    chk("rst_initDone", W'(initDone), W'(1'b0));
    chk("rst_we", W'(sramWriteEnable), W'(0));
    exp_q.delete();
    model_run = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    n = 0;
    while (!initDone && n < 600) begin
      chk("sweep_addr", W'(sramWriteAddr), W'(n));
      chk("sweep_we", W'(sramWriteEnable), W'({NM{1'b1}}));
      if (n < 2) begin
        chk("sweep_rspValid", W'(rspValid), W'(1'b0));
        chk("sweep_reqReady", W'(reqReady), W'(1'b0));
      end
      n++;
      @(negedge clk);
      #1;
    end
    chk("init_cycles", W'(n), W'(ROWS));
    model_run = 1'b1;
    for (int r = 0; r < int'(ROWS); r++) ref_mem[r] = '0;
  endtask

  initial begin
    logic acc;
    logic [W-1:0] d;
    total = 0; bad = 0; n_rsp = 0; model_run = 1'b0;
    reset = 1'b1; reqValid = 1'b0; reqWrite = 1'b0; reqAddr = '0;
    reqData = '0; reqMask = '0; rspReady = 1'b1;
    repeat (2) @(negedge clk);

    // Sweep length and zero-filled rows at both ends and the middle.
    do_reset();
    rd(AW'(0), 1'b1, acc);
    rd(AW'(255), 1'b1, acc);
    rd(AW'(511), 1'b1, acc);
    idle(1'b1); idle(1'b1);

    // Partial-mask write keeps the upper words at zero.
    wr(AW'(5), {64{8'hAA}}, 8'h0F);
    rd(AW'(5), 1'b1, acc);
    idle(1'b1);
    chk("row5_model", ref_mem[5], {{4{64'h0}}, {4{64'hAAAA_AAAA_AAAA_AAAA}}});
    idle(1'b1);

    // Read immediately after write returns the new data.
    d = rand_row();
    wr(AW'(7), d, '1);
    rd(AW'(7), 1'b1, acc);
    idle(1'b1); idle(1'b1);

    // Back-to-back reads with no bubbles.
    n_rsp = 0;
    for (int i = 1; i <= 8; i++) begin
      rd(AW'(i), 1'b1, acc);
      chk("b2b_accept", W'(acc), W'(1'b1));
    end
    idle(1'b1);
    chk("b2b_rsp_count", W'(n_rsp), W'(8));
    idle(1'b1);

    // Backpressure: only two reads fit, then drain and accept the third.
    wr(AW'(22), rand_row(), '1);
    rd(AW'(20), 1'b0, acc); chk("bp_acc0", W'(acc), W'(1'b1));
    rd(AW'(21), 1'b0, acc); chk("bp_acc1", W'(acc), W'(1'b1));
    rd(AW'(22), 1'b0, acc); chk("bp_acc2", W'(acc), W'(1'b0));
    repeat (3) begin
      rd(AW'(22), 1'b0, acc);
      chk("bp_hold", W'(acc), W'(1'b0));
    end
    acc = 1'b0;
    for (int i = 0; i < 5 && !acc; i++) rd(AW'(22), 1'b1, acc);
    chk("bp_third_accepted", W'(acc), W'(1'b1));
    repeat (3) idle(1'b1);

    // Randomized mix against the reference model.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) < 4)
        step(1'b1, 1'b1, AW'($urandom_range(0, 15)), rand_row(), NM'($urandom), 1'($urandom_range(0, 9) < 7), acc);
      else
        step(1'($urandom_range(0, 9) < 8), 1'b0, AW'($urandom_range(0, 15)), '0, '0,
             1'($urandom_range(0, 9) < 7), acc);
    end
    repeat (3) idle(1'b1);

    // Reset with two buffered responses discards them and re-sweeps.
    rd(AW'(30), 1'b0, acc);
    rd(AW'(7), 1'b0, acc);
    idle(1'b0);
    chk("pre_reset_buffered", W'(rspValid), W'(1'b1));
    do_reset();
    rd(AW'(7), 1'b1, acc);
    rd(AW'(5), 1'b1, acc);
    idle(1'b1); idle(1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sram_req_ctrl.md
SRAM_REQ_CTRL -- requirements
Module: sram_req_ctrl

Interface
REQ-001 Param WIDTH, 512, SRAM row width in bits.
REQ-002 Param LOG_NUM_ROWS, 9, row address width; NUM_ROWS = 2**LOG_NUM_ROWS.
REQ-003 Param WORD_SIZE, 64, write-enable granularity; NM = WIDTH/WORD_SIZE mask bits.
REQ-004 Param CLEAR_ON_RESET, 1, 1 = zero-fill sweep after reset.
REQ-005 clk  in  1  single clock; all state on posedge.
REQ-006 reset  in  1  synchronous, active-high.
REQ-007 reqValid  in  1  client request valid.
REQ-008 reqReady  out  1  controller accepts request.
REQ-009 reqWrite  in  1  1 = write, 0 = read.
REQ-010 reqAddr  in  LOG_NUM_ROWS  row address.
REQ-011 reqData  in  WIDTH  write data.
REQ-012 reqMask  in  NM  per-word write enable.
REQ-013 rspValid  out  1  read response valid.
REQ-014 rspReady  in  1  client takes response.
REQ-015 rspData  out  WIDTH  read data.
REQ-016 sramReadAddr  out  LOG_NUM_ROWS  to SRAM read port.
REQ-017 sramReadData  in  WIDTH  from SRAM, registered, valid one cycle after address.
REQ-018 sramWriteAddr / sramWriteData / sramWriteEnable  out  LOG_NUM_ROWS / WIDTH / NM  to SRAM write port.
REQ-019 initDone  out  1  high once in RUN.

Function
REQ-020 FSM states INIT and RUN; reset enters INIT if CLEAR_ON_RESET=1, else RUN.
REQ-021 INIT: row counter 0..NUM_ROWS-1, one row per cycle: sramWriteAddr=counter, sramWriteData=0, sramWriteEnable=all ones; reqReady=0.
REQ-022 INIT -> RUN on the cycle after row NUM_ROWS-1 is written; sweep takes exactly NUM_ROWS cycles.
REQ-023 Handshake: accept = reqValid && reqReady; reqReady = RUN && (fifoCount + pending) < 2, independent of reqValid and reqWrite.
REQ-024 Accepted write: same cycle, drive sramWriteAddr=reqAddr, sramWriteData=reqData, sramWriteEnable=reqMask; no response generated; mask 0 is a legal no-op.
REQ-025 sramWriteEnable = 0 in every cycle without an accepted write (RUN) or sweep (INIT).
REQ-026 Accepted read: same cycle drive sramReadAddr=reqAddr; set pending for next cycle.
REQ-027 Read latency: rspValid asserted in cycle after accept; if FIFO empty, rspData = sramReadData combinationally; else rspData = FIFO head.
REQ-028 Pending read data not consumed that cycle is pushed into 2-entry FIFO at end of cycle; responses strictly in request order.
REQ-029 Throughput: with rspReady=1 continuously, one request accepted per cycle, no bubbles.
REQ-030 Write to row A accepted cycle N, read of A accepted cycle N+1 or later returns new data; only one request per cycle, so no same-cycle read/write conflict exists.
REQ-031 Backpressure: rspValid && !rspReady holds rspData stable until taken.
REQ-032 sramReadAddr holds last value when idle (don't-care to SRAM).

Reset
REQ-033 During/after reset: reqReady=0, rspValid=0, initDone=0 (or initDone=1, reqReady=1 next cycle when CLEAR_ON_RESET=0), fifoCount=0, pending=0, sweep counter=0, sramWriteEnable=0 in the reset cycle.
REQ-034 Reset mid-operation discards pending read and FIFO contents; in-progress sweep restarts at row 0.

Structure
REQ-035 Package sram_pkg holds WIDTH/LOG_NUM_ROWS/WORD_SIZE defaults and the state enum {INIT, RUN}.
REQ-036 One sub-module sram_rsp_fifo: 2-entry WIDTH-bit FIFO with count, push/pop, synchronous reset.

Verification
REQ-037 Reset, CLEAR_ON_RESET=1 -> initDone rises after exactly 512 cycles; read of rows 0, 255, 511 returns 0.
REQ-038 Write row 5 = 0x..AA with mask 8'h0F, then read 5 -> low 4 words AA, upper 4 words 0.
REQ-039 Write row 7 cycle N, read row 7 cycle N+1 -> rspValid cycle N+2 with new data.
REQ-040 Back-to-back reads rows 1..8, rspReady=1 -> reqReady never drops, 8 responses in order, one per cycle.
REQ-041 rspReady=0 with 3 reads issued -> only 2 accepted, reqReady=0, rspData stable; release -> responses drain in order, third read then accepted.
REQ-042 Reset asserted with 2 responses buffered -> rspValid=0 next cycle, sweep restarts at row 0.
